// File: rtl/serial_add_unit_if.sv
// Operand/result handshake bundle for serial_add_unit: start/ready/done plus
// operands and registered results.
interface serial_add_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C_out;
  logic             overflow;

  modport master (
    output start, op_sub, A, B, C_in,
    input  ready, busy, done, Sum, C_out, overflow
  );

  modport slave (
    input  start, op_sub, A, B, C_in,
    output ready, busy, done, Sum, C_out, overflow
  );
endinterface

// File: rtl/serial_add_unit.sv
// Area-minimal adder/subtractor: one shared 2-bit ripple slice walks the
// operands two bits per clock, carrying between slices in a register.
module add2_slice (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  input  logic       i_c,
  output logic [1:0] o_s,
  output logic       o_c
);
  logic w_c1;

  always_comb begin
    o_s[0] = i_a[0] ^ i_b[0] ^ i_c;
    w_c1   = (i_a[0] & i_b[0]) | ((i_a[0] ^ i_b[0]) & i_c);
    o_s[1] = i_a[1] ^ i_b[1] ^ w_c1;
    o_c    = (i_a[1] & i_b[1]) | ((i_a[1] ^ i_b[1]) & w_c1);
  end
endmodule

module serial_add_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  serial_add_unit_if.slave bus
);
  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] LAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [1:0]       w_s;
  logic             w_c;

  add2_slice u_slice (
    .i_a (r_a[{r_k, 1'b0} +: 2]),
    .i_b (r_b[{r_k, 1'b0} +: 2]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    bus.ready  = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (r_state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (r_k == LAST) w_next = DONE;
      end
      DONE: begin
        bus.ready = 1'b1;
        bus.done  = 1'b1;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is folded into the latch: B is inverted and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_k     <= '0;
      r_a     <= bus.A;
      r_b     <= bus.B ^ {WIDTH{bus.op_sub}};
      r_carry <= bus.op_sub ? 1'b1 : bus.C_in;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum[{r_k, 1'b0} +: 2] <= w_s;
      r_carry                 <= w_c;
      if (r_k == LAST) begin
        r_k    <= '0;
        r_cout <= w_c;
        r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[1] != r_a[WIDTH-1]);
      end else begin
        r_k <= r_k + KW'(1);
      end
    end
  end

  always_comb begin
    bus.Sum      = r_sum;
    bus.C_out    = r_cout;
    bus.overflow = r_ovf;
  end
endmodule

// File: tb/tb_serial_add_unit.sv
// Self-checking bench for serial_add_unit: directed table, random ops against
// an arithmetic reference, and multi-cycle handshake/reset sequences.
module tb_serial_add_unit;
  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  serial_add_unit_if #(.WIDTH(W)) bus ();

  serial_add_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t         r;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (r.sum[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, input logic st);
    bus.A      = a;
    bus.B      = b;
    bus.C_in   = cin;
    bus.op_sub = sub;
    bus.start  = st;
  endtask

  // Counts negedges from the drive negedge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 100);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sub, output int lat);
    @(negedge clk);
    check("ready_before_start", {63'd0, bus.ready}, 64'd1);
    drive(a, b, cin, sub, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    bus.C_in = 1'($urandom);
    bus.op_sub = 1'($urandom);
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t tbl[6];

  initial begin
    int   lat;
    res_t m;
    logic [W-1:0] ra, rb;
    logic rc, rs;
    logic saw_done;
    logic [W-1:0] qa[4], qb[4];
    logic qc[4], qs[4];

    tbl[0] = '{32'h00000005, 32'h00000003, 1'b0, 1'b0, 32'h00000008, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[2] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[3] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[4] = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
    tbl[5] = '{32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};

    drive('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {63'd0, bus.ready}, 64'd1);
    check("rst_busy",  {63'd0, bus.busy},  64'd0);
    check("rst_done",  {63'd0, bus.done},  64'd0);
    check("rst_sum",   {32'd0, bus.Sum},   64'd0);
    check("rst_cout",  {63'd0, bus.C_out}, 64'd0);
    check("rst_ovf",   {63'd0, bus.overflow}, 64'd0);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, lat);
      check("tbl_latency", 64'(lat), 64'd17);
      check("tbl_sum",  {32'd0, bus.Sum},      {32'd0, tbl[i].exp_sum});
      check("tbl_cout", {63'd0, bus.C_out},    {63'd0, tbl[i].exp_cout});
      check("tbl_ovf",  {63'd0, bus.overflow}, {63'd0, tbl[i].exp_ovf});
      @(negedge clk);
      check("tbl_done_one_cycle", {63'd0, bus.done}, 64'd0);
      check("tbl_sum_hold", {32'd0, bus.Sum}, {32'd0, tbl[i].exp_sum});
    end

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) rb = ~ra;
      if (i % 8 == 1) rb = ra;
      rc = 1'($urandom);
      rs = 1'($urandom);
      m = model(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, lat);
      check("rnd_latency", 64'(lat), 64'd17);
      check("rnd_sum",  {32'd0, bus.Sum},      {32'd0, m.sum});
      check("rnd_cout", {63'd0, bus.C_out},    {63'd0, m.cout});
      check("rnd_ovf",  {63'd0, bus.overflow}, {63'd0, m.ovf});
    end

    // start pulsed with fresh operands every cycle while busy: ignored
    @(negedge clk);
    ra = 32'h12345678; rb = 32'h0F0F0F0F;
    m = model(ra, rb, 1'b1, 1'b0);
    drive(ra, rb, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      check("busy_ready_low", {63'd0, bus.ready}, 64'd0);
      check("busy_flag",      {63'd0, bus.busy},  64'd1);
      drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_done", {63'd0, bus.done}, 64'd1);
    check("busy_sum",  {32'd0, bus.Sum},  {32'd0, m.sum});
    check("busy_cout", {63'd0, bus.C_out}, {63'd0, m.cout});
    @(negedge clk);

    // Back-to-back with start held high
    for (int i = 0; i < 4; i++) begin
      qa[i] = $urandom; qb[i] = $urandom;
      qc[i] = 1'($urandom); qs[i] = 1'($urandom);
    end
    drive(qa[0], qb[0], qc[0], qs[0], 1'b1);
    for (int i = 0; i < 4; i++) begin
      m = model(qa[i], qb[i], qc[i], qs[i]);
      wait_done(lat);
      check("b2b_latency", 64'(lat), 64'd17);
      check("b2b_sum",  {32'd0, bus.Sum},      {32'd0, m.sum});
      check("b2b_cout", {63'd0, bus.C_out},    {63'd0, m.cout});
      check("b2b_ovf",  {63'd0, bus.overflow}, {63'd0, m.ovf});
      if (i < 3) drive(qa[i+1], qb[i+1], qc[i+1], qs[i+1], 1'b1);
      else       bus.start = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_done", {63'd0, bus.done}, 64'd0);

    // Reset on the 5th RUN edge aborts the operation
    @(negedge clk);
    drive(32'hFFFF0000, 32'h0001FFFF, 1'b1, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {63'd0, bus.ready}, 64'd1);
    check("abort_busy",  {63'd0, bus.busy},  64'd0);
    check("abort_sum",   {32'd0, bus.Sum},   64'd0);
    check("abort_cout",  {63'd0, bus.C_out}, 64'd0);
    check("abort_ovf",   {63'd0, bus.overflow}, 64'd0);
    saw_done = bus.done;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      saw_done = saw_done | bus.done;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);
    do_op(32'd1, 32'd1, 1'b0, 1'b0, lat);
    check("after_abort_latency", 64'(lat), 64'd17);
    check("after_abort_sum", {32'd0, bus.Sum}, 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/serial_add_unit.md
# serial_add_unit

Multi-cycle, area-minimal adder/subtractor that computes a WIDTH-bit sum two bits per clock through a single instance of the team's 2-bit ripple adder slice, holding the inter-slice carry in a register. It sits between the EX-stage operand muxes and the result writeback mux, and serves the low-area processor variant where one shared 2-bit slice replaces the full-width ALU adder. Handshake is start/ready/done; the pipeline stalls while the unit is busy.

## Interface
- WIDTH, 32, operand width in bits; must be even and ≥ 2
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- op_sub  input  1  0: A + B + C_in; 1: A − B (A + ~B + 1, C_in ignored)
- A  input  WIDTH  operand A, sampled with start
- B  input  WIDTH  operand B, sampled with start
- C_in  input  1  carry-in for add; sampled with start
- ready  output  1  unit can accept start this cycle
- busy  output  1  computation in progress
- done  output  1  one-cycle pulse; Sum/C_out/overflow valid
- Sum  output  WIDTH  result
- C_out  output  1  carry out of bit WIDTH−1
- overflow  output  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1, busy=0, done=0. start=1 → latch A, B^{WIDTH{op_sub}}, carry=op_sub ? 1 : C_in; slice index k=0; go to RUN.
- RUN: ready=0, busy=1. Each edge: the slice adds latched A[2k+1:2k], B'[2k+1:2k] and the carry register; writes Sum[2k+1:2k]; the slice carry-out updates the carry register; k increments. The edge processing k=WIDTH/2−1 moves to DONE.
- DONE: done=1, ready=1, busy=0; C_out = final carry register. start=1 → behaves as in IDLE (latch, go to RUN, back-to-back); else → IDLE.
- overflow computed at the final slice: (A[W−1] == B'[W−1]) && (Sum[W−1] != A[W−1]); registered alongside C_out.
- Sum, C_out and overflow hold their values from DONE until the next start is accepted; they are cleared to 0 on the edge that accepts start. Intermediate Sum bits are visible in RUN but are not valid.
- start while busy=1 is ignored (no queueing, no error).
- Subtraction carry semantics: C_out=1 means no borrow.

## Timing
- Reset: on an edge with rst=1, state=IDLE, k=0, carry=0, Sum=0, C_out=0, overflow=0, done=0, busy=0, ready=1. rst overrides start.
- Reset mid-RUN: operation aborted, no done pulse, ready=1 in the cycle after the reset edge.
- Latency: start sampled at edge E0; RUN occupies edges E1..E(WIDTH/2); done=1 during the cycle after E(WIDTH/2), i.e. WIDTH/2+1 edges after E0 (17 for WIDTH=32).
- Throughput: with start held at 1 in DONE, one result every WIDTH/2+1 cycles.
- Counter k is exactly log2(WIDTH/2) bits wide (minimum 1); no wrap beyond WIDTH/2−1 occurs in RUN.
- Operand inputs may change freely after the accepting edge.

## Test plan
- WIDTH=32, A=0x00000005, B=0x00000003, C_in=0, op_sub=0 → done 17 edges after start; Sum=0x00000008, C_out=0, overflow=0; done high exactly one cycle.
- A=0xFFFFFFFF, B=0x00000001, C_in=0 → Sum=0x00000000, C_out=1, overflow=0; A=0x7FFFFFFF, B=0x00000000, C_in=1 → Sum=0x80000000, C_out=0, overflow=1.
- op_sub=1, A=0x80000000, B=0x00000001, C_in=1 (ignored) → Sum=0x7FFFFFFF, C_out=1, overflow=1; op_sub=1, A=5, B=5 → Sum=0, C_out=1, overflow=0; op_sub=1, A=3, B=5 → Sum=0xFFFFFFFE, C_out=0.
- Pulse start=1 with new operands every cycle while busy → only the first operation is computed; ready=0 throughout RUN; results match the first operands.
- Hold start=1 continuously with operands changing on each acceptance → a new operation is accepted in each DONE cycle; done pulses every 17 cycles with the correct results for each.
- Assert rst for one cycle at the 5th RUN edge → no done pulse; Sum=0, C_out=0, overflow=0, ready=1 on the next cycle; a following add of 1+1 gives Sum=2.
